tbb_nibble_writer: RTL and testbench

- Upstream host-side stage for the tbb1143 sound-chip core.
- Accepts register-write commands (4-bit register address + 8-bit data) on a valid/ready interface and buffers them in a small FIFO.
- Replays each command as three strobed writes on the core's nibble bus (A0, D[3:0], WR).
- Bus outputs connect directly to the core's A0/D0-D3/WR inputs, so firmware or a test harness never bit-bangs the bus timing.

---
 rtl/tbb_nibble_writer.sv | 189 ++++++++++++++++++
 tb/tb_tbb_nibble_writer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbb_nibble_writer.sv
// rtl/tbb_nibble_writer.sv - queued register-write commands replayed as strobed nibble-bus writes
module tbb_nibble_writer #(
    parameter int DEPTH     = 4,
    parameter int WR_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [3:0]               CMD_ADDR,
    input  logic [7:0]               CMD_DATA,
    output logic                     BUS_A0,
    output logic [3:0]               BUS_D,
    output logic                     BUS_WR,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [2:0]    WRC      = 3'(WR_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // FIFO storage: entry = {addr[3:0], data[7:0]}
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_nxt;
    logic          push;
    logic          pop;
    logic          empty;
    logic [11:0]   head;

    // Sequencer registers and their next values
    state_t      state;
    state_t      state_nxt;
    logic [1:0]  phase;
    logic [1:0]  phase_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [11:0] work;
    logic [11:0] work_nxt;
    logic        a0_q;
    logic        a0_nxt;
    logic [3:0]  d_q;
    logic [3:0]  d_nxt;
    logic        wr_q;
    logic        wr_nxt;

    // Nibble select: phase 0 = address, 1 = low data nibble, 2 = high data nibble
    function automatic logic [4:0] nib(input logic [11:0] w, input logic [1:0] p);
        case (p)
            2'd0:    nib = {1'b1, w[11:8]};
            2'd1:    nib = {1'b0, w[3:0]};
            default: nib = {1'b0, w[7:4]};
        endcase
    endfunction

    // Ready is registered, so a pop on a full FIFO cannot open the door for a push in the same cycle
    assign push  = CMD_VALID && CMD_READY;
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (!push && pop) begin
            level_nxt = level - LW'(1);
        end
    end

    // FIFO data array; contents need no reset because the pointers define validity
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {CMD_ADDR, CMD_DATA};
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            CMD_READY <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level     <= level_nxt;
            CMD_READY <= (level_nxt != FULL_LVL);
        end
    end

    // Sequencer state and registered bus outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            phase <= 2'd0;
            cnt   <= 3'd0;
            work  <= 12'd0;
            a0_q  <= 1'b0;
            d_q   <= 4'd0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
            a0_q  <= a0_nxt;
            d_q   <= d_nxt;
            wr_q  <= wr_nxt;
        end
    end

    // Next-state and next bus values; A0/D are only updated when entering SETUP or IDLE
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        work_nxt  = work;
        pop       = 1'b0;
        a0_nxt    = a0_q;
        d_nxt     = d_q;
        wr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop             = 1'b1;
                    work_nxt        = head;
                    phase_nxt       = 2'd0;
                    state_nxt       = SETUP;
                    {a0_nxt, d_nxt} = nib(head, 2'd0);
                end else begin
                    a0_nxt = 1'b0;
                    d_nxt  = 4'd0;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                wr_nxt    = 1'b1;
                cnt_nxt   = 3'd1;
            end
            STROBE: begin
                if (cnt == WRC) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                    wr_nxt  = 1'b1;
                end
            end
            HOLD: begin
                if (phase != 2'd2) begin
                    phase_nxt       = phase + 2'd1;
                    state_nxt       = SETUP;
                    {a0_nxt, d_nxt} = nib(work, phase + 2'd1);
                end else if (!empty) begin
                    pop             = 1'b1;
                    work_nxt        = head;
                    phase_nxt       = 2'd0;
                    state_nxt       = SETUP;
                    {a0_nxt, d_nxt} = nib(head, 2'd0);
                end else begin
                    state_nxt = IDLE;
                    a0_nxt    = 1'b0;
                    d_nxt     = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign BUS_A0 = a0_q;
    assign BUS_D  = d_q;
    assign BUS_WR = wr_q;
    assign BUSY   = (state != IDLE) || !empty;
    assign LEVEL  = level;

endmodule

// File: tb/tb_tbb_nibble_writer.sv
// tb/tb_tbb_nibble_writer.sv - directed self-checking bench for tbb_nibble_writer
module tb_tbb_nibble_writer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [3:0] CMD_ADDR = 4'd0;
    logic [7:0] CMD_DATA = 8'd0;
    logic       BUS_A0;
    logic [3:0] BUS_D;
    logic       BUS_WR;
    logic       BUSY;
    logic [2:0] LEVEL;

    logic       c_valid = 1'b0;
    logic [3:0] xaddr = 4'd0;
    logic [7:0] xdata = 8'd0;
    logic [1:0] w_ready, w_a0, w_wr, w_busy;
    logic [3:0] w_d [2];
    logic [2:0] w_lvl [2];

    int n_vec = 0;
    int n_bad = 0;

    tbb_nibble_writer #(.DEPTH(4), .WR_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .BUS_A0(BUS_A0), .BUS_D(BUS_D),
        .BUS_WR(BUS_WR), .BUSY(BUSY), .LEVEL(LEVEL)
    );

    tbb_nibble_writer #(.DEPTH(4), .WR_CYCLES(1)) u1 (
        .CLK(CLK), .RST(RST), .CMD_VALID(c_valid), .CMD_READY(w_ready[0]),
        .CMD_ADDR(xaddr), .CMD_DATA(xdata), .BUS_A0(w_a0[0]), .BUS_D(w_d[0]),
        .BUS_WR(w_wr[0]), .BUSY(w_busy[0]), .LEVEL(w_lvl[0])
    );

    tbb_nibble_writer #(.DEPTH(4), .WR_CYCLES(7)) u7 (
        .CLK(CLK), .RST(RST), .CMD_VALID(c_valid), .CMD_READY(w_ready[1]),
        .CMD_ADDR(xaddr), .CMD_DATA(xdata), .BUS_A0(w_a0[1]), .BUS_D(w_d[1]),
        .BUS_WR(w_wr[1]), .BUSY(w_busy[1]), .LEVEL(w_lvl[1])
    );

    always #5 CLK = ~CLK;

    // Bus monitor for the main instance: one record per WR=1 window
    typedef struct packed {
        logic       a0;
        logic [3:0] d;
        logic [3:0] len;
        logic       stab;
        int         t;
    } nib_t;

    nib_t nq[$];
    nib_t cur;
    logic in_wr = 1'b0;
    int   cyc_n = 0;

    always @(negedge CLK) begin
        cyc_n = cyc_n + 1;
        if (!RST) begin
            in_wr = 1'b0;
        end else if (BUS_WR) begin
            if (!in_wr) begin
                cur.a0   = BUS_A0;
                cur.d    = BUS_D;
                cur.len  = 4'd1;
                cur.stab = 1'b1;
                cur.t    = cyc_n;
                in_wr    = 1'b1;
            end else begin
                cur.len = cur.len + 4'd1;
                if (BUS_A0 !== cur.a0 || BUS_D !== cur.d) cur.stab = 1'b0;
            end
        end else if (in_wr) begin
            nq.push_back(cur);
            in_wr = 1'b0;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        n_vec++; if (CMD_READY !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %0b want 0", CMD_READY); end
        n_vec++; if ({BUS_WR, BUS_A0, BUS_D} !== 6'd0) begin n_bad++; $display("FAIL rst_bus got %b want 000000", {BUS_WR, BUS_A0, BUS_D}); end
        n_vec++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0b want 0", BUSY); end
        n_vec++; if (LEVEL !== 3'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", LEVEL); end
        RST = 1'b1;
        tick();
        n_vec++; if (CMD_READY !== 1'b1) begin n_bad++; $display("FAIL rel_ready got %0b want 1", CMD_READY); end
        n_vec++; if (w_ready !== 2'b11) begin n_bad++; $display("FAIL rel_ready_wrc got %b want 11", w_ready); end
        n_vec++; if (BUSY !== 1'b0 || LEVEL !== 3'd0) begin n_bad++; $display("FAIL rel_idle busy=%0b level=%0d want 0/0", BUSY, LEVEL); end
    endtask

    task automatic test_single();
        logic [4:0] e [3];
        logic       ew;
        e[0] = 5'h15; e[1] = 5'h03; e[2] = 5'h0A;
        nq.delete();
        CMD_VALID = 1'b1; CMD_ADDR = 4'h5; CMD_DATA = 8'hA3;
        tick();
        CMD_VALID = 1'b0;
        n_vec++; if (LEVEL !== 3'd1 || BUSY !== 1'b1) begin n_bad++; $display("FAIL single_queued level=%0d busy=%0b want 1/1", LEVEL, BUSY); end
        n_vec++; if ({BUS_WR, BUS_A0, BUS_D} !== 6'd0) begin n_bad++; $display("FAIL single_idle_bus got %b want 000000", {BUS_WR, BUS_A0, BUS_D}); end
        for (int c = 0; c < 12; c++) begin
            tick();
            ew = ((c % 4) == 1) || ((c % 4) == 2);
            n_vec++;
            if ({BUSY, BUS_WR, BUS_A0, BUS_D} !== {1'b1, ew, e[c / 4]}) begin
                n_bad++;
                $display("FAIL single_cyc%0d busy/wr/a0/d got %b want %b", c, {BUSY, BUS_WR, BUS_A0, BUS_D}, {1'b1, ew, e[c / 4]});
            end
        end
        n_vec++; if (LEVEL !== 3'd0) begin n_bad++; $display("FAIL single_level got %0d want 0", LEVEL); end
        tick();
        n_vec++; if ({BUSY, BUS_WR, BUS_A0, BUS_D} !== 7'd0) begin n_bad++; $display("FAIL single_end got %b want 0000000", {BUSY, BUS_WR, BUS_A0, BUS_D}); end
        n_vec++; if (nq.size() !== 3) begin n_bad++; $display("FAIL single_nibbles got %0d want 3", nq.size()); end
    endtask

    task automatic test_burst();
        logic [11:0] bc [6];
        int          hist[$];
        int          idx, t, maxl, j, gaps;
        logic        acc;
        logic [4:0]  en;
        bc[0] = 12'h312; bc[1] = 12'hC9E; bc[2] = 12'h700;
        bc[3] = 12'hFFF; bc[4] = 12'h05A; bc[5] = 12'h9C4;
        nq.delete();
        idx = 0; t = 0; maxl = 0;
        while ((idx < 6 || BUSY) && t < 300) begin
            if (idx < 6) begin
                CMD_VALID = 1'b1; {CMD_ADDR, CMD_DATA} = bc[idx];
            end else begin
                CMD_VALID = 1'b0;
            end
            acc = CMD_VALID && CMD_READY;
            tick();
            t++;
            if (acc) idx++;
            hist.push_back(int'(LEVEL));
            if (int'(LEVEL) > maxl) maxl = int'(LEVEL);
            if (LEVEL == 3'd4) begin
                n_vec++; if (CMD_READY !== 1'b0) begin n_bad++; $display("FAIL burst_full_ready got %0b want 0", CMD_READY); end
            end
        end
        CMD_VALID = 1'b0;
        n_vec++; if (t >= 300) begin n_bad++; $display("FAIL burst_timeout cycles %0d want <300", t); end
        n_vec++; if (maxl !== 4) begin n_bad++; $display("FAIL burst_max_level got %0d want 4", maxl); end
        j = -1;
        for (int i = 0; i + 2 < hist.size(); i++) begin
            if (hist[i] == 4 && hist[i + 1] != 4) begin j = i; break; end
        end
        n_vec++;
        if (j < 0) begin
            n_bad++; $display("FAIL burst_full_pop level never left 4");
        end else if (hist[j + 1] != 3 || hist[j + 2] != 4) begin
            n_bad++; $display("FAIL burst_full_pop levels %0d,%0d want 3,4", hist[j + 1], hist[j + 2]);
        end
        n_vec++; if (nq.size() !== 18) begin n_bad++; $display("FAIL burst_nibbles got %0d want 18", nq.size()); end
        if (nq.size() == 18) begin
            gaps = 0;
            for (int i = 0; i < 18; i++) begin
                case (i % 3)
                    0:       en = {1'b1, bc[i / 3][11:8]};
                    1:       en = {1'b0, bc[i / 3][3:0]};
                    default: en = {1'b0, bc[i / 3][7:4]};
                endcase
                n_vec++;
                if ({nq[i].a0, nq[i].d, nq[i].len, nq[i].stab} !== {en, 4'd2, 1'b1}) begin
                    n_bad++;
                    $display("FAIL burst_nib%0d a0/d/len/stab got %b want %b", i, {nq[i].a0, nq[i].d, nq[i].len, nq[i].stab}, {en, 4'd2, 1'b1});
                end
                if (i > 0 && nq[i].t - nq[i - 1].t != 4) gaps++;
            end
            n_vec++; if (gaps !== 0) begin n_bad++; $display("FAIL burst_back_to_back irregular strobe spacings %0d want 0", gaps); end
        end
    endtask

    task automatic test_reset_mid();
        int   i, t;
        logic acc;
        nq.delete();
        i = 0; t = 0;
        while (i < 3 && t < 20) begin
            CMD_VALID = 1'b1; CMD_ADDR = 4'(i + 2); CMD_DATA = 8'(8'h40 + i);
            acc = CMD_READY;
            tick();
            t++;
            if (acc) i++;
        end
        CMD_VALID = 1'b0;
        t = 0;
        while (!(nq.size() >= 1 && BUS_WR === 1'b1) && t < 40) begin tick(); t++; end
        n_vec++; if (t >= 40) begin n_bad++; $display("FAIL rmid_reach_strobe timeout nibbles=%0d", nq.size()); end
        #2;
        RST = 1'b0;
        #1;
        n_vec++; if (BUS_WR !== 1'b0) begin n_bad++; $display("FAIL rmid_wr got %0b want 0", BUS_WR); end
        n_vec++; if (LEVEL !== 3'd0) begin n_bad++; $display("FAIL rmid_level got %0d want 0", LEVEL); end
        n_vec++; if (BUSY !== 1'b0 || CMD_READY !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_ready got %b want 00", {BUSY, CMD_READY}); end
        tick();
        RST = 1'b1;
        tick();
        nq.delete();
        n_vec++; if (CMD_READY !== 1'b1 || BUS_A0 !== 1'b0) begin n_bad++; $display("FAIL rmid_release ready/a0 got %b want 10", {CMD_READY, BUS_A0}); end
        CMD_VALID = 1'b1; CMD_ADDR = 4'h1; CMD_DATA = 8'hFF;
        tick();
        CMD_VALID = 1'b0;
        t = 0;
        while (BUSY && t < 40) begin tick(); t++; end
        tick();
        n_vec++; if (nq.size() !== 3) begin n_bad++; $display("FAIL rmid_new_nibbles got %0d want 3", nq.size()); end
        if (nq.size() == 3) begin
            n_vec++;
            if ({nq[0].a0, nq[0].d, nq[1].a0, nq[1].d, nq[2].a0, nq[2].d} !== 15'b1_0001_0_1111_0_1111) begin
                n_bad++; $display("FAIL rmid_new_cmd got %b want 100010111101111", {nq[0].a0, nq[0].d, nq[1].a0, nq[1].d, nq[2].a0, nq[2].d});
            end
            n_vec++;
            if ({nq[0].len, nq[1].len, nq[2].len, nq[0].stab, nq[1].stab, nq[2].stab} !== {4'd2, 4'd2, 4'd2, 3'b111}) begin
                n_bad++; $display("FAIL rmid_new_timing got %b want 001000100010111", {nq[0].len, nq[1].len, nq[2].len, nq[0].stab, nq[1].stab, nq[2].stab});
            end
        end
    endtask

    task automatic test_wr_cycles();
        int         blen [2], nc [2], run [2], serr [2], wrc;
        int         nl [2][3];
        logic [4:0] nv [2][3];
        logic [4:0] held [2];
        logic       pw [2];
        logic [4:0] e [3];
        e[0] = 5'h1B; e[1] = 5'h0D; e[2] = 5'h06;
        for (int j = 0; j < 2; j++) begin
            blen[j] = 0; nc[j] = 0; run[j] = 0; serr[j] = 0; held[j] = 5'd0; pw[j] = 1'b0;
            for (int n = 0; n < 3; n++) begin nl[j][n] = 0; nv[j][n] = 5'd0; end
        end
        c_valid = 1'b1; xaddr = 4'hB; xdata = 8'h6D;
        tick();
        c_valid = 1'b0;
        tick();
        for (int cy = 0; cy < 40; cy++) begin
            for (int j = 0; j < 2; j++) begin
                if (w_busy[j]) blen[j]++;
                if (w_wr[j]) begin
                    if (!pw[j]) begin
                        held[j] = {w_a0[j], w_d[j]};
                        run[j] = 1;
                    end else begin
                        run[j]++;
                        if ({w_a0[j], w_d[j]} !== held[j]) serr[j]++;
                    end
                end else if (pw[j]) begin
                    if (nc[j] < 3) begin nv[j][nc[j]] = held[j]; nl[j][nc[j]] = run[j]; end
                    nc[j]++;
                end
                pw[j] = w_wr[j];
            end
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            wrc = (j == 0) ? 1 : 7;
            n_vec++; if (blen[j] !== 3 * (wrc + 2)) begin n_bad++; $display("FAIL wrc%0d_cmd_len got %0d want %0d", wrc, blen[j], 3 * (wrc + 2)); end
            n_vec++; if (nc[j] !== 3) begin n_bad++; $display("FAIL wrc%0d_strobes got %0d want 3", wrc, nc[j]); end
            n_vec++; if (serr[j] !== 0) begin n_bad++; $display("FAIL wrc%0d_stable changes during WR %0d want 0", wrc, serr[j]); end
            for (int n = 0; n < 3; n++) begin
                n_vec++;
                if (nv[j][n] !== e[n] || nl[j][n] !== wrc) begin
                    n_bad++; $display("FAIL wrc%0d_nib%0d a0/d=%b len=%0d want %b len=%0d", wrc, n, nv[j][n], nl[j][n], e[n], wrc);
                end
            end
            n_vec++; if (w_lvl[j] !== 3'd0 || w_ready[j] !== 1'b1) begin n_bad++; $display("FAIL wrc%0d_final level=%0d ready=%0b want 0/1", wrc, w_lvl[j], w_ready[j]); end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] eq[$];
        logic        acc;
        int          n, t;
        nq.delete();
        n = 0; t = 0;
        while (n < 13 && t < 500) begin
            CMD_VALID = ($urandom_range(0, 3) != 0);
            CMD_ADDR  = 4'($urandom);
            CMD_DATA  = 8'($urandom);
            acc = CMD_VALID && CMD_READY;
            if (acc) eq.push_back({CMD_ADDR, CMD_DATA});
            tick();
            t++;
            if (acc) n++;
        end
        CMD_VALID = 1'b0;
        t = 0;
        while (BUSY && t < 300) begin tick(); t++; end
        tick();
        n_vec++; if (eq.size() !== 13 || nq.size() !== 39) begin n_bad++; $display("FAIL wrap_counts pushed=%0d nibbles=%0d want 13/39", eq.size(), nq.size()); end
        if (eq.size() == 13 && nq.size() == 39) begin
            for (int i = 0; i < 13; i++) begin
                n_vec++;
                if ({nq[3 * i].a0, nq[3 * i + 1].a0, nq[3 * i + 2].a0, nq[3 * i].d, nq[3 * i + 2].d, nq[3 * i + 1].d} !== {3'b100, eq[i]}) begin
                    n_bad++;
                    $display("FAIL wrap_cmd%0d got a0=%b addr/data=%h want a0=100 addr/data=%h", i,
                             {nq[3 * i].a0, nq[3 * i + 1].a0, nq[3 * i + 2].a0},
                             {nq[3 * i].d, nq[3 * i + 2].d, nq[3 * i + 1].d}, eq[i]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_reset_mid();
        test_wr_cycles();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
